// File: rtl/ltc2311_emulator_if.sv
// Serial bus between the ADC reader (master) and the LTC2311-16 emulator (slave).
interface ltc2311_emulator_if;
  logic cnv_n;
  logic sck;
  logic sdo;

  modport master (output cnv_n, output sck, input sdo);
  modport slave  (input cnv_n, input sck, output sdo);
endinterface

// File: rtl/ltc2311_emulator.sv
// Device-side model of the LTC2311-16 serial interface: oversamples cnv_n/sck on clk
// and shifts a latched sample word out on sdo, MSB first, one bit per sck fall.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for cnv rise, sdo held low
//   CONVERT | sample latched, busy high, counting conversion cycles
//   SHIFT   | presenting bits on sdo, advancing on each sck fall
module ltc2311_emulator #(
  parameter int DATA_WIDTH  = 16,
  parameter int CONV_CYCLES = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ltc2311_emulator_if.slave     bus,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  err_clear,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  early_cnv_err,
  output logic [15:0]           frame_count
);

  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CONV_MAX = CW'(CONV_CYCLES);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CONVERT, SHIFT} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  cnv_sync;
  logic [SYNC_STAGES-1:0]  sck_sync;
  logic                    cnv_d;
  logic                    sck_d;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [CW-1:0]           conv_cnt;
  logic [BW-1:0]           bit_cnt;
  logic                    sdo_r;

  logic                    cnv_s;
  logic                    sck_s;
  logic                    cnv_rise;
  logic                    cnv_fall;
  logic                    sck_fall;
  logic [CW-1:0]           conv_inc;
  logic                    conv_early;

  assign bus.sdo = sdo_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnv_sync <= '0;
      sck_sync <= '1;
      cnv_d    <= 1'b0;
      sck_d    <= 1'b1;
    end else begin
      cnv_sync <= {cnv_sync[SYNC_STAGES-2:0], bus.cnv_n};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      cnv_d    <= cnv_sync[SYNC_STAGES-1];
      sck_d    <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign cnv_s    = cnv_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cnv_rise = cnv_s & ~cnv_d;
  assign cnv_fall = ~cnv_s & cnv_d;
  assign sck_fall = ~sck_s & sck_d;

  // The cycle in which the fall is seen counts as a conversion cycle, so cnv_n
  // held high for exactly CONV_CYCLES clocks is accepted as a full conversion.
  assign conv_inc   = (conv_cnt == CONV_MAX) ? conv_cnt : conv_cnt + 1'b1;
  assign conv_early = (conv_inc < CONV_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      sdo_r         <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      early_cnv_err <= 1'b0;
      frame_count   <= 16'h0000;
      shift_reg     <= '0;
      conv_cnt      <= '0;
      bit_cnt       <= '0;
    end else begin
      frame_done <= 1'b0;
      if (err_clear) early_cnv_err <= 1'b0;
      case (state)
        IDLE: begin
          sdo_r <= 1'b0;
          if (cnv_rise) begin
            shift_reg <= sample_in;
            conv_cnt  <= '0;
            busy      <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          if (cnv_fall) begin
            busy    <= 1'b0;
            sdo_r   <= shift_reg[DATA_WIDTH-1];
            bit_cnt <= BW'(1);
            state   <= SHIFT;
            if (conv_early) early_cnv_err <= 1'b1;
          end else begin
            conv_cnt <= conv_inc;
          end
        end
        SHIFT: begin
          // A new conversion request aborts the frame in progress.
          if (cnv_rise) begin
            shift_reg <= sample_in;
            conv_cnt  <= '0;
            busy      <= 1'b1;
            sdo_r     <= 1'b0;
            state     <= CONVERT;
          end else if (sck_fall) begin
            if (bit_cnt < BIT_LAST) begin
              shift_reg <= shift_reg << 1;
              sdo_r     <= shift_reg[DATA_WIDTH-2];
              bit_cnt   <= bit_cnt + 1'b1;
            end else begin
              sdo_r       <= 1'b0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'h0001;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
